// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: owns the single data-memory port. Runs fixed-latency accesses
// for the MEM-stage CPU and for a DMA engine, stalls the CPU until its access
// completes, grants DMA bounded bursts, and forces a DMA win once it has been
// denied for STARVE_LIMIT cycles.
//
// Handshake summary: the CPU holds cpu_readM/cpu_writeM as a level and is frozen
// by cpu_stall until the cycle its access completes (cpu_stall low). The DMA holds
// dma_req as a level; dma_grant marks ownership, and dma_ack is a one-cycle pulse
// in the last strobe cycle of each word, on whose closing edge the DMA engine
// moves to its next word. Dropping dma_req mid-word still completes that word.
module d_mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int DMA_BURST    = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_readM,
    input  logic                 cpu_writeM,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dma_req,
    input  logic                 dma_writeM,
    input  logic [WORD_SIZE-1:0] dma_address,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic [WORD_SIZE-1:0] dma_rdata,
    output logic                 dma_grant,
    output logic                 dma_ack,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WL_W  = $clog2(DMA_BURST + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [WL_W-1:0]  WL_LOAD  = WL_W'(DMA_BURST);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CPU_ACC  = 3'd1;
    localparam logic [2:0] S_CPU_DONE = 3'd2;
    localparam logic [2:0] S_DMA_ACC  = 3'd3;
    localparam logic [2:0] S_DMA_NEXT = 3'd4;

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WL_W-1:0]      r_words_left;
    logic [SC_W-1:0]      r_starve_cnt;
    logic [WORD_SIZE-1:0] r_cpu_rdata;
    logic [WORD_SIZE-1:0] r_dma_rdata;
    logic                 r_dma_grant;
    logic                 r_mem_readM;
    logic                 r_mem_writeM;
    logic [WORD_SIZE-1:0] r_mem_address;
    logic [WORD_SIZE-1:0] r_mem_wdata;

    logic w_cpu_req;
    logic w_acc_last;
    logic w_dma_win;

    assign w_cpu_req  = cpu_readM | cpu_writeM;
    assign w_acc_last = (r_cnt == '0);
    // DMA wins from IDLE when the CPU is quiet or DMA has waited long enough.
    assign w_dma_win  = dma_req && (!w_cpu_req || (r_starve_cnt >= SC_MAX));

    assign cpu_stall   = w_cpu_req && (r_state != S_CPU_DONE);
    assign dma_ack     = (r_state == S_DMA_ACC) && w_acc_last;
    assign cpu_rdata   = r_cpu_rdata;
    assign dma_rdata   = r_dma_rdata;
    assign dma_grant   = r_dma_grant;
    assign mem_readM   = r_mem_readM;
    assign mem_writeM  = r_mem_writeM;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign dbg_state   = r_state;

    // Access sequencer: picks an owner in IDLE, holds the strobe for MEM_LATENCY cycles, captures read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_words_left  <= '0;
            r_cpu_rdata   <= '0;
            r_dma_rdata   <= '0;
            r_dma_grant   <= 1'b0;
            r_mem_readM   <= 1'b0;
            r_mem_writeM  <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dma_win) begin
                        r_state       <= S_DMA_ACC;
                        r_dma_grant   <= 1'b1;
                        r_words_left  <= WL_LOAD;
                        r_mem_readM   <= !dma_writeM;
                        r_mem_writeM  <= dma_writeM;
                        r_mem_address <= dma_address;
                        r_mem_wdata   <= dma_wdata;
                        r_cnt         <= CNT_LOAD;
                    end else if (w_cpu_req) begin
                        // A store wins when both CPU request lines are up.
                        r_state       <= S_CPU_ACC;
                        r_mem_readM   <= !cpu_writeM;
                        r_mem_writeM  <= cpu_writeM;
                        r_mem_address <= cpu_address;
                        r_mem_wdata   <= cpu_wdata;
                        r_cnt         <= CNT_LOAD;
                    end
                end
                S_CPU_ACC: begin
                    if (!w_acc_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (r_mem_readM) begin
                            r_cpu_rdata <= mem_rdata;
                        end
                        r_mem_readM  <= 1'b0;
                        r_mem_writeM <= 1'b0;
                        r_state      <= S_CPU_DONE;
                    end
                end
                S_CPU_DONE: begin
                    // Lets the pipeline advance so the finished request is not replayed.
                    r_state <= S_IDLE;
                end
                S_DMA_ACC: begin
                    if (!w_acc_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_dma_rdata  <= mem_rdata;
                        r_mem_readM  <= 1'b0;
                        r_mem_writeM <= 1'b0;
                        r_words_left <= r_words_left - WL_W'(1);
                        r_state      <= S_DMA_NEXT;
                    end
                end
                S_DMA_NEXT: begin
                    if ((r_words_left == '0) || !dma_req) begin
                        r_dma_grant <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_mem_readM   <= !dma_writeM;
                        r_mem_writeM  <= dma_writeM;
                        r_mem_address <= dma_address;
                        r_mem_wdata   <= dma_wdata;
                        r_cnt         <= CNT_LOAD;
                        r_state       <= S_DMA_ACC;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts cycles DMA asks without owning the bus, cleared when it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_dma_win) begin
            r_starve_cnt <= '0;
        end else if (dma_req && !r_dma_grant && (r_starve_cnt < SC_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: directed timelines for CPU, DMA, arbitration, starvation and
// reset-mid-burst, then a randomized mix of CPU accesses and short DMA bursts.
// Expected timing comes from cycle arithmetic on MEM_LATENCY/DMA_BURST/STARVE_LIMIT
// and expected data from a shadow copy of the memory contents.
module tb_d_mem_arbiter;
  localparam int W  = 16;
  localparam int ML = 2;
  localparam int DB = 12;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic reset;
  logic cpu_readM, cpu_writeM;
  logic [W-1:0] cpu_address, cpu_wdata, cpu_rdata;
  logic cpu_stall;
  logic dma_req, dma_writeM;
  logic [W-1:0] dma_address, dma_wdata, dma_rdata;
  logic dma_grant, dma_ack;
  logic mem_readM, mem_writeM;
  logic [W-1:0] mem_address, mem_wdata, mem_rdata;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // memory device behind the arbiter, plus a preload port used during reset
  logic [W-1:0] dev_mem [0:63];
  logic pre_we;
  logic [5:0] pre_a;
  logic [W-1:0] pre_d;

  // shadow of the memory contents and the DMA engine's current word
  logic [W-1:0] shadow [0:63];
  logic [W-1:0] exp_cpu_rdata;
  logic [5:0] cur_a;
  bit cur_wr;
  logic [W-1:0] cur_d;

  d_mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(ML), .DMA_BURST(DB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_writeM(dma_writeM),
    .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_grant(dma_grant), .dma_ack(dma_ack),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // memory device: writes whenever the write strobe is up, read data only under the read strobe
  always @(posedge clk) begin
    if (pre_we) dev_mem[pre_a] <= pre_d;
    else if (mem_writeM) dev_mem[mem_address[5:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_readM ? dev_mem[mem_address[5:0]] : '0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge; strobes must never overlap
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("strobe_excl", 32'(mem_readM & mem_writeM), 32'd0);
  endtask

  task automatic dma_new_word(input bit force_rd);
    cur_a = 6'($urandom_range(0, 63));
    cur_wr = force_rd ? 1'b0 : 1'($urandom_range(0, 1));
    cur_d = 16'($urandom);
    dma_address = {10'b0, cur_a};
    dma_writeM = cur_wr;
    dma_wdata = cur_d;
  endtask

  // called in a cycle where an ack is expected: checks the word on the bus
  task automatic dma_word_end(output bit pend, output logic [W-1:0] pv);
    chk("dma_rd_strobe", 32'(mem_readM), 32'(!cur_wr));
    chk("dma_wr_strobe", 32'(mem_writeM), 32'(cur_wr));
    chk("dma_mem_addr", 32'(mem_address), 32'(cur_a));
    if (cur_wr) begin
      chk("dma_mem_wdata", 32'(mem_wdata), 32'(cur_d));
      shadow[cur_a] = cur_d;
      pend = 1'b0;
      pv = '0;
    end else begin
      pend = 1'b1;
      pv = shadow[cur_a];
    end
  endtask

  // isolated CPU access starting from an idle bus
  task automatic cpu_access(input bit wr, input logic [5:0] a, input logic [W-1:0] d);
    bit ers, ews;
    cyc();
    cpu_address = {10'b0, a};
    cpu_wdata = d;
    cpu_writeM = wr;
    cpu_readM = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k <= ML + 1; k++) begin
      if (k > 0) cyc();
      #1;
      ers = !wr && k >= 1 && k <= ML;
      ews = wr && k >= 1 && k <= ML;
      chk("cpu_stall", 32'(cpu_stall), 32'(k <= ML));
      chk("cpu_rd_strobe", 32'(mem_readM), 32'(ers));
      chk("cpu_wr_strobe", 32'(mem_writeM), 32'(ews));
      if (ers || ews) chk("cpu_mem_addr", 32'(mem_address), 32'(a));
      if (ews) chk("cpu_mem_wdata", 32'(mem_wdata), 32'(d));
    end
    if (wr) shadow[a] = d;
    else exp_cpu_rdata = shadow[a];
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
    cpu_readM = 1'b0;
    cpu_writeM = 1'b0;
  endtask

  // full burst with dma_req held, then regrant, then dma_req dropped mid-word
  task automatic dma_full();
    int last_ack, g2, a2;
    bit eg, ea, pend;
    logic [W-1:0] pv;
    last_ack = ML + (DB - 1) * (ML + 1);
    g2 = last_ack + 3;
    a2 = g2 + ML - 1;
    pend = 1'b0;
    pv = '0;
    cyc();
    dma_req = 1'b1;
    dma_new_word(1'b0);
    for (int k = 0; k <= a2 + 2; k++) begin
      if (k > 0) cyc();
      #1;
      eg = (k >= 1 && k <= last_ack + 1) || (k >= g2 && k <= a2 + 1);
      ea = (k >= ML && k <= last_ack && ((k - ML) % (ML + 1)) == 0) || (k == a2);
      chk("burst_grant", 32'(dma_grant), 32'(eg));
      chk("burst_ack", 32'(dma_ack), 32'(ea));
      if (pend) begin
        chk("burst_rdata", 32'(dma_rdata), 32'(pv));
        pend = 1'b0;
      end
      if (ea) begin
        dma_word_end(pend, pv);
        dma_new_word(1'b0);
      end
      if (k == g2) dma_req = 1'b0;
    end
  endtask

  // cpu_readM and dma_req rise together: CPU first, then DMA after CPU_DONE and IDLE
  task automatic sim_arb();
    int gs, ak;
    bit pend;
    logic [W-1:0] pv;
    logic [5:0] a;
    gs = ML + 3;
    ak = gs + ML - 1;
    a = 6'($urandom_range(0, 63));
    pend = 1'b0;
    pv = '0;
    cyc();
    cpu_readM = 1'b1;
    cpu_address = {10'b0, a};
    dma_req = 1'b1;
    dma_new_word(1'b0);
    for (int k = 0; k <= ak + 2; k++) begin
      if (k > 0) cyc();
      #1;
      chk("arb_stall", 32'(cpu_stall), 32'(k <= ML));
      if (k <= ML + 1) chk("arb_cpu_strobe", 32'(mem_readM), 32'(k >= 1 && k <= ML));
      chk("arb_grant", 32'(dma_grant), 32'(k >= gs && k <= ak + 1));
      chk("arb_ack", 32'(dma_ack), 32'(k == ak));
      if (pend) begin
        chk("arb_dma_rdata", 32'(dma_rdata), 32'(pv));
        pend = 1'b0;
      end
      if (k == ML + 1) begin
        exp_cpu_rdata = shadow[a];
        chk("arb_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        cpu_readM = 1'b0;
      end
      if (k == ak) dma_word_end(pend, pv);
      if (k == gs) dma_req = 1'b0;
    end
  endtask

  // back-to-back CPU loads with dma_req held: DMA must win once it has waited SL cycles
  task automatic starve();
    int p, gk, ak, fin;
    bit done, pend;
    logic [W-1:0] pv;
    logic [5:0] a;
    p = ML + 2;
    gk = ((SL + p - 1) / p) * p;
    ak = gk + ML;
    fin = gk + 2 * ML + 3;
    pend = 1'b0;
    pv = '0;
    a = 6'($urandom_range(0, 63));
    cyc();
    cpu_readM = 1'b1;
    cpu_address = {10'b0, a};
    dma_req = 1'b1;
    dma_new_word(1'b1);
    for (int k = 0; k <= fin; k++) begin
      if (k > 0) cyc();
      #1;
      done = (k < gk && (k % p) == ML + 1) || (k == fin);
      chk("starve_stall", 32'(cpu_stall), 32'(!done));
      chk("starve_grant", 32'(dma_grant), 32'(k >= gk + 1 && k <= ak + 1));
      chk("starve_ack", 32'(dma_ack), 32'(k == ak));
      if (pend) begin
        chk("starve_dma_rdata", 32'(dma_rdata), 32'(pv));
        pend = 1'b0;
      end
      if (k == ak) dma_word_end(pend, pv);
      if (k == gk + 1) dma_req = 1'b0;
      if (done) begin
        exp_cpu_rdata = shadow[a];
        chk("starve_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        if (k == fin) begin
          cpu_readM = 1'b0;
        end else begin
          a = 6'($urandom_range(0, 63));
          cpu_address = {10'b0, a};
        end
      end
    end
  endtask

  // reset asserted in the first strobe cycle of DMA word 5
  task automatic rst_mid_dma();
    int rk;
    bit ea, pend;
    logic [W-1:0] pv;
    rk = 1 + 4 * (ML + 1);
    pend = 1'b0;
    pv = '0;
    cyc();
    dma_req = 1'b1;
    dma_new_word(1'b1);
    for (int k = 0; k <= rk; k++) begin
      if (k > 0) cyc();
      #1;
      ea = k >= ML && k < rk && ((k - ML) % (ML + 1)) == 0;
      chk("rst_pre_grant", 32'(dma_grant), 32'(k >= 1));
      chk("rst_pre_ack", 32'(dma_ack), 32'(ea));
      if (pend) begin
        chk("rst_pre_rdata", 32'(dma_rdata), 32'(pv));
        pend = 1'b0;
      end
      if (ea) begin
        dma_word_end(pend, pv);
        dma_new_word(1'b1);
      end
    end
    chk("rst_mid_strobe", 32'(mem_readM), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(dma_grant), 32'd0);
    chk("rst_rd_strobe", 32'(mem_readM), 32'd0);
    chk("rst_wr_strobe", 32'(mem_writeM), 32'd0);
    chk("rst_ack", 32'(dma_ack), 32'd0);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    exp_cpu_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_hold_ack", 32'(dma_ack), 32'd0);
      chk("rst_hold_grant", 32'(dma_grant), 32'd0);
    end
    dma_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rel_grant", 32'(dma_grant), 32'd0);
    cpu_access(1'b0, 6'($urandom_range(0, 63)), '0);
  endtask

  // short burst of len words; dma_req dropped in the last word's ack cycle
  task automatic dma_short(input int len);
    int la;
    bit eg, ea, pend;
    logic [W-1:0] pv;
    la = ML + (len - 1) * (ML + 1);
    pend = 1'b0;
    pv = '0;
    cyc();
    dma_req = 1'b1;
    dma_new_word(1'b0);
    for (int k = 0; k <= la + 2; k++) begin
      if (k > 0) cyc();
      #1;
      eg = k >= 1 && k <= la + 1;
      ea = k >= ML && k <= la && ((k - ML) % (ML + 1)) == 0;
      chk("short_grant", 32'(dma_grant), 32'(eg));
      chk("short_ack", 32'(dma_ack), 32'(ea));
      if (pend) begin
        chk("short_rdata", 32'(dma_rdata), 32'(pv));
        pend = 1'b0;
      end
      if (ea) begin
        dma_word_end(pend, pv);
        if (k == la) dma_req = 1'b0;
        else dma_new_word(1'b0);
      end
    end
  endtask

  initial begin
    int op;
    reset = 1'b1;
    cpu_readM = 1'b0;
    cpu_writeM = 1'b0;
    cpu_address = '0;
    cpu_wdata = '0;
    dma_req = 1'b0;
    dma_writeM = 1'b0;
    dma_address = '0;
    dma_wdata = '0;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    exp_cpu_rdata = '0;
    cur_a = '0;
    cur_wr = 1'b0;
    cur_d = '0;

    // preload memory while reset is held
    for (int i = 0; i < 64; i++) begin
      cyc();
      pre_we = 1'b1;
      pre_a = i[5:0];
      pre_d = (i == 16) ? 16'hBEEF : 16'($urandom);
      shadow[i] = pre_d;
    end
    cyc();
    pre_we = 1'b0;
    #1;
    chk("reset_grant", 32'(dma_grant), 32'd0);
    chk("reset_ack", 32'(dma_ack), 32'd0);
    chk("reset_rd_strobe", 32'(mem_readM), 32'd0);
    chk("reset_wr_strobe", 32'(mem_writeM), 32'd0);
    chk("reset_mem_addr", 32'(mem_address), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    cyc();
    reset = 1'b0;

    cpu_access(1'b0, 6'h10, '0);
    chk("cpu_rd_beef", 32'(cpu_rdata), 32'h0000BEEF);
    cpu_access(1'b1, 6'h20, 16'h1234);
    cpu_access(1'b0, 6'h20, '0);
    chk("cpu_rd_1234", 32'(cpu_rdata), 32'h00001234);
    dma_full();
    sim_arb();
    starve();
    rst_mid_dma();

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) cpu_access(1'b0, 6'($urandom_range(0, 63)), '0);
      else if (op == 1) cpu_access(1'b1, 6'($urandom_range(0, 63)), 16'($urandom));
      else dma_short($urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
